// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port between NUM_REQ wclk-domain
// producers; enforces a maximum burst length and revokes grants from stalled owners.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 8
) (
  input  logic                          wclk,
  input  logic                          rrst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          wfull,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          busy,
  output logic                          abort
);

  localparam int unsigned OWN_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W  = $clog2(MAX_BURST) + 1;
  localparam int unsigned IDLE_W = 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [OWN_W-1:0]     last_owner_q, last_owner_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 abort_q, abort_d;

  logic [DATA_WIDTH-1:0] beat [NUM_REQ];
  logic                  sel_found;
  logic [OWN_W-1:0]      sel_idx;
  logic                  accept;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign beat[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First requester after the previous owner, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!sel_found && req[OWN_W'((32'(last_owner_q) + k) % NUM_REQ)]) begin
        sel_found = 1'b1;
        sel_idx   = OWN_W'((32'(last_owner_q) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge wclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_owner_q <= OWN_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      gnt_q        <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      gnt_q        <= gnt_d;
      abort_q      <= abort_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    gnt_d        = gnt_q;
    abort_d      = 1'b0;
    accept       = 1'b0;
    winc         = 1'b0;
    wdata        = '0;
    ack          = '0;

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d    = S_BURST;
          owner_d    = sel_idx;
          gnt_d      = NUM_REQ'(1) << sel_idx;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      S_BURST: begin
        accept       = req[owner_q] & ~wfull;
        winc         = accept;
        wdata        = beat[owner_q];
        ack[owner_q] = accept;
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          idle_cnt_d = '0;
          // Last beat or burst cap reached: hand the port to the next requester.
          if (req_last[owner_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
            state_d      = S_IDLE;
            last_owner_d = owner_q;
            gnt_d        = '0;
          end
        end else if (!req[owner_q]) begin
          if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
            state_d      = S_IDLE;
            last_owner_d = owner_q;
            gnt_d        = '0;
            abort_d      = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign gnt   = gnt_q;
  assign abort = abort_q;
  assign busy  = (state_q == S_BURST);

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of the team's asynchronous FIFO between `NUM_REQ` producers in the `wclk` domain. Each producer sends bursts of beats. The arbiter grants one producer at a time and forwards its beats to the FIFO as `winc`/`wdata`, gated by the FIFO's `wfull`. It enforces a maximum burst length and releases stalled owners after a timeout.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of producers (2..8).
- `DATA_WIDTH`, default 8: beat width; must equal the FIFO `DATA_WIDTH`.
- `MAX_BURST`, default 16: maximum beats per grant (2..256).
- `IDLE_TIMEOUT`, default 8: consecutive cycles the owner may hold `req` low before its grant is revoked (1..255).

Ports:
- `wclk`, in, 1: write-domain clock; all logic is on its rising edge.
- `rrst_n`, in, 1: reset, asynchronous, active-low.
- `req`, in, `NUM_REQ`: per-producer beat valid.
- `req_last`, in, `NUM_REQ`: marks the final beat of a burst; qualified by `req`.
- `req_data`, in, `NUM_REQ*DATA_WIDTH`: producer i's beat is at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `wfull`, in, 1: FIFO full flag from the write-pointer handler.
- `gnt`, out, `NUM_REQ`: registered one-hot owner; all zero when idle.
- `ack`, out, `NUM_REQ`: combinational; bit i is high when producer i's beat is accepted this cycle.
- `winc`, out, 1: FIFO write enable; combinational.
- `wdata`, out, `DATA_WIDTH`: FIFO write data; combinational mux of the owner's beat.
- `busy`, out, 1: high in BURST.
- `abort`, out, 1: one-cycle registered pulse when a grant is revoked by timeout.

## Operation

State machine has two states, IDLE and BURST.

- **IDLE**
  - `gnt` = 0, `winc` = 0, `wdata` = 0.
  - If any `req` bit is high, select the first requester searching from (`last_owner` + 1) mod `NUM_REQ` upward with wrap.
  - Register the selection into `gnt` and owner, clear `beat_cnt` and `idle_cnt`, and go to BURST.
- **BURST**
  - Accept condition: `accept = req[owner] & ~wfull`.
  - `winc` = `accept`; `wdata` = `req_data[owner]`; `ack[owner]` = `accept`.
  - On each accept, increment `beat_cnt` (width clog2(`MAX_BURST`)+1) and clear `idle_cnt`.
  - Release conditions (on release, go to IDLE, `last_owner` <= owner, `gnt` <= 0):
    - an accepted beat with `req_last[owner]`, or
    - an accepted beat with `beat_cnt == MAX_BURST-1` (forced release; the producer re-arbitrates for the rest of its burst).
  - Stall while `req[owner]` is low: `idle_cnt` increments.
    - When `idle_cnt` reaches `IDLE_TIMEOUT-1` with `req[owner]` still low: go to IDLE, pulse `abort`, set `last_owner` <= owner.
  - Stall on `wfull` with `req[owner]` high: no accept, no `idle_cnt` increment, no timeout. The grant is held indefinitely.
- Non-owner `req` bits are ignored; their `ack` stays 0.
- `req_last` without `req` has no effect.

## Timing

- Reset values: state IDLE, `gnt` = 0, `last_owner` = `NUM_REQ-1` (so requester 0 wins first), `beat_cnt` = 0, `idle_cnt` = 0, `busy` = 0, `abort` = 0, `winc` = 0, `wdata` = 0, `ack` = 0.
- Arbitration latency:
  - `req` rising in IDLE in cycle N gives `gnt` in cycle N+1.
  - The first beat can be accepted in N+1.
- Release costs one bubble: the release beat is in cycle N, IDLE is cycle N+1, and the next owner's `gnt` appears in N+2.
- `wfull` is sampled combinationally in the same cycle. Because `wfull` is registered in the FIFO, `winc` never rises while `wfull` = 1, so no write errors can occur.
- A single requester streaming continuously gets `MAX_BURST` beats, then one bubble, then is re-granted.
- `rrst_n` asserted mid-burst immediately forces IDLE and the reset values; any in-flight beat is not written. After deassertion, the first grant goes to requester 0.
- `abort` is high for exactly one cycle, the IDLE cycle after revocation.

## Test plan

- **Reset then single request.** After reset, hold `req` = 4'b0100 with 3 beats (0xA1, 0xA2, 0xA3+last). Required: `gnt` = 4'b0100 one cycle after `req`; `winc` high for 3 consecutive cycles with matching `wdata`; `busy` drops after the last beat.
- **Round-robin fairness.** Hold all 4 `req` high, each sending 2-beat bursts. Required grant order 0, 1, 2, 3, 0, with exactly one bubble between bursts.
- **Full back-pressure.** Assert `wfull` for 5 cycles mid-burst. Required: `winc` = 0 and `ack` = 0 during those cycles; no `abort`; remaining beats delivered in order after `wfull` falls.
- **Max burst.** With `MAX_BURST` = 16, requester 1 streams 20 beats with `req` never low. Required: 16 writes, release, one bubble, re-grant, then 4 more writes.
- **Timeout.** With `IDLE_TIMEOUT` = 8, the owner drops `req` after 1 beat while requester 2 waits. Required: `abort` pulses 8 cycles after the drop, then requester 2 is granted.
- **Reset mid-burst.** Assert `rrst_n` low during the 3rd beat. Required: `gnt`, `winc` and `busy` go to 0 immediately; after release, requester 0 gets priority.
